// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming KxK sliding-window generator.
// Raster-order pixels (CH channels packed per beat) feed K-1 chained line
// buffers; a KxK window register is emitted at the configured stride with
// valid/ready backpressure, a last-window flag and an end-of-frame pulse.
module conv_window_gen #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned IMG_W     = 28,
  parameter int unsigned IMG_H     = 28,
  parameter int unsigned K         = 5,
  parameter int unsigned CH        = 1,
  parameter int unsigned STRIDE    = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        soft_clr,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CH*DATA_BITS-1:0]     data_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [K*K*CH*DATA_BITS-1:0] window,
  output logic                        out_last,
  output logic                        frame_done
);

  localparam int unsigned PIX_W = CH * DATA_BITS;
  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned KM1   = K - 1;
  // Parity of K-1: with stride 2, valid columns/rows share this parity.
  localparam logic        K_PAR = 1'(KM1 % 2);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             frame_done_q, frame_done_d;
  logic             accept, shift_en;
  logic             col_end, row_end, frame_end, win_pos;

  logic [PIX_W-1:0] lb_q  [KM1][IMG_W];
  logic [PIX_W-1:0] win_q [K][K];
  logic [PIX_W-1:0] tap   [K];

  // Handshake: a stalled window blocks input; soft_clr discards the beat.
  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign shift_en  = accept && !soft_clr;
  assign col_end   = (col_q == COL_W'(IMG_W - 1));
  assign row_end   = (row_q == ROW_W'(IMG_H - 1));
  assign frame_end = col_end && row_end;

  // Window-complete position of the pixel being accepted (compare only).
  always_comb begin
    win_pos = (row_q >= ROW_W'(KM1)) && (col_q >= COL_W'(KM1));
    if (STRIDE == 2) begin
      win_pos = win_pos && (row_q[0] == K_PAR) && (col_q[0] == K_PAR);
    end
  end

  // Raster position counters.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (soft_clr) begin
      col_d = '0;
      row_d = '0;
    end else if (accept) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // Output flag next-state: load on accept, drain when the consumer takes it.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    frame_done_d = 1'b0;
    if (soft_clr) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else if (accept) begin
      out_valid_d  = win_pos;
      out_last_d   = frame_end;
      frame_done_d = frame_end;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Column taps: line-buffer outputs (oldest row first), newest row is data_in.
  always_comb begin
    tap[KM1] = data_in;
    for (int r = 0; r < int'(KM1); r++) begin
      tap[r] = lb_q[r][IMG_W-1];
    end
  end

  // Chained line buffers; stale contents are masked by the position check.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      for (int r = 0; r < int'(KM1); r++) begin
        lb_q[r][0] <= tap[r+1];
        for (int j = 1; j < int'(IMG_W); j++) begin
          lb_q[r][j] <= lb_q[r][j-1];
        end
      end
    end
  end

  // Window register: shift toward column 0, load the new column at K-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < int'(K); r++) begin
        for (int c = 0; c < int'(K); c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else if (shift_en) begin
      for (int r = 0; r < int'(K); r++) begin
        for (int c = 0; c < int'(KM1); c++) begin
          win_q[r][c] <= win_q[r][c+1];
        end
        win_q[r][KM1] <= tap[r];
      end
    end
  end

  // Flatten the window: element (r,c) pixel at (r*K+c)*PIX_W.
  always_comb begin
    window = '0;
    for (int r = 0; r < int'(K); r++) begin
      for (int c = 0; c < int'(K); c++) begin
        window[(r*int'(K)+c)*int'(PIX_W) +: PIX_W] = win_q[r][c];
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign frame_done = frame_done_q;

endmodule
